// File: rtl/alu_bist.sv
// Built-in self-test sequencer for the 64-bit ALU: walks a vector table,
// drives operands, waits for the result to settle, and scores {zero, busW}.
//
// state  | meaning
// IDLE   | waiting for start after reset
// FETCH  | vec_addr presented, memory read in flight
// DRIVE  | vector data valid, operands latched onto the ALU buses
// SETTLE | operands held while the ALU result settles
// CHECK  | result compared against the latched expected value
// DONE   | run finished, results held until next start
module alu_bist #(
  parameter int NUM_VECTORS   = 11,
  parameter int SETTLE_CYCLES = 2,
  parameter int ADDR_W        = 4
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              start,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [63:0]       vec_a,
  input  logic [63:0]       vec_b,
  input  logic [3:0]        vec_ctrl,
  input  logic [64:0]       vec_exp,
  output logic [63:0]       busA,
  output logic [63:0]       busB,
  output logic [3:0]        ctrl,
  input  logic [63:0]       busW,
  input  logic              zero,
  output logic              busy,
  output logic              done,
  output logic              pass_all,
  output logic [7:0]        pass_count,
  output logic              fail_seen,
  output logic [ADDR_W-1:0] fail_index
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DRIVE  = 3'd2,
    SETTLE = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5
  } stateT;

  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_VECTORS - 1);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  stateT             state;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        settleCnt;
  logic [64:0]       expQ;
  logic              resultMatch;

  assign resultMatch = ({zero, busW} == expQ);

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state      <= IDLE;
      idx        <= '0;
      settleCnt  <= '0;
      expQ       <= '0;
      vec_addr   <= '0;
      busA       <= '0;
      busB       <= '0;
      ctrl       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_all   <= 1'b0;
      pass_count <= '0;
      fail_seen  <= 1'b0;
      fail_index <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx        <= '0;
            vec_addr   <= '0;
            pass_count <= '0;
            fail_seen  <= 1'b0;
            fail_index <= '0;
            done       <= 1'b0;
            pass_all   <= 1'b0;
            busy       <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: state <= DRIVE;
        DRIVE: begin
          busA      <= vec_a;
          busB      <= vec_b;
          ctrl      <= vec_ctrl;
          expQ      <= vec_exp;
          settleCnt <= '0;
          state     <= SETTLE;
        end
        SETTLE: begin
          settleCnt <= settleCnt + 4'd1;
          if (settleCnt == SETTLE_LAST) state <= CHECK;
        end
        CHECK: begin
          if (resultMatch) begin
            pass_count <= pass_count + 8'd1;
          end else if (!fail_seen) begin
            fail_index <= idx;
            fail_seen  <= 1'b1;
          end
          // pass_all folds in this final compare since pass_count/fail_seen lag by one edge
          if (idx == LAST_IDX) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            pass_all <= resultMatch && !fail_seen;
            state    <= DONE;
          end else begin
            idx      <= idx + 1'b1;
            vec_addr <= idx + 1'b1;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
